hazard_scoreboard: RTL and testbench

Parametrised successor to the per-stage decode controllers. It tracks every in-flight register write from E to W in a shift-register scoreboard with self-decrementing Tnew, and counts down a multi-cycle mult/div busy window. From these it produces the D-stage stall and the per-operand forward selects for rs and rt. It sits beside the D stage and takes pre-decoded fields from the D controller, replacing the static per-stage Tnew/RFWr decoders.

---
 rtl/hazard_scoreboard_pkg.sv | 34 +++
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_operand_check.sv | 39 +++
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    // Widths of the scoreboard entry fields.
    localparam int SB_REG_AW = 5;
    localparam int SB_TNEW_W = 3;

    // Mult/div start kinds presented by the D controller (3 is reserved = none).
    localparam logic [1:0] MD_NONE = 2'd0;
    localparam logic [1:0] MD_MUL  = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;

    // Forward select value meaning "take the register file".
    localparam int FWD_RF = 0;

    // One in-flight register write.
    typedef struct packed {
        logic                 wr;
        logic [SB_REG_AW-1:0] dst;
        logic [SB_TNEW_W-1:0] tnew;
    } sb_entry_t;

    // Tnew counts down as an entry ages and parks at zero.
    function automatic logic [SB_TNEW_W-1:0] tnew_dec(input logic [SB_TNEW_W-1:0] t);
        logic [SB_TNEW_W-1:0] r;
        if (t == {SB_TNEW_W{1'b0}}) begin
            r = t;
        end else begin
            r = t - SB_TNEW_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage side-band between the decode controller and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int TNEW_W = 3,
    parameter int SEL_W  = 2
);
    logic              d_valid;
    logic              d_wr;
    logic [REG_AW-1:0] d_dst;
    logic [TNEW_W-1:0] d_tnew;
    logic [REG_AW-1:0] d_rs;
    logic              d_rs_use;
    logic [TNEW_W-1:0] d_rs_tuse;
    logic [REG_AW-1:0] d_rt;
    logic              d_rt_use;
    logic [TNEW_W-1:0] d_rt_tuse;
    logic [1:0]        d_md_start;
    logic              d_md_use;
    logic              stall;
    logic [SEL_W-1:0]  fwd_rs;
    logic [SEL_W-1:0]  fwd_rt;
    logic              md_busy;

    // Decode controller side.
    modport master (
        output d_valid, d_wr, d_dst, d_tnew, d_rs, d_rs_use, d_rs_tuse,
               d_rt, d_rt_use, d_rt_tuse, d_md_start, d_md_use,
        input  stall, fwd_rs, fwd_rt, md_busy
    );

    // Scoreboard side.
    modport slave (
        input  d_valid, d_wr, d_dst, d_tnew, d_rs, d_rs_use, d_rs_tuse,
               d_rt, d_rt_use, d_rt_tuse, d_md_start, d_md_use,
        output stall, fwd_rs, fwd_rt, md_busy
    );
endinterface

// File: rtl/hazard_operand_check.sv
// Per-operand lookup: youngest matching in-flight write decides hazard and forward.
module hazard_operand_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int SEL_W  = 2
) (
    input  sb_entry_t [STAGES-1:0] entries,
    input  logic [SB_REG_AW-1:0]   op_reg,
    input  logic                   op_use,
    input  logic [SB_TNEW_W-1:0]   op_tuse,
    output logic                   hazard,
    output logic [SEL_W-1:0]       fwd
);

    logic found_s;

    // Scan from E towards W; the first hit shadows every older entry.
    always_comb begin
        hazard  = 1'b0;
        fwd     = SEL_W'(FWD_RF);
        found_s = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (!found_s && entries[i].wr && (entries[i].dst == op_reg) &&
                (op_reg != {SB_REG_AW{1'b0}})) begin
                found_s = 1'b1;
                hazard  = op_use && (entries[i].tnew > op_tuse);
                if (entries[i].tnew == {SB_TNEW_W{1'b0}}) begin
                    fwd = SEL_W'(i + 1);
                end else begin
                    fwd = SEL_W'(FWD_RF);
                end
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall / forward generator: shift-register write scoreboard plus mult/div busy window.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int REG_AW  = SB_REG_AW,
    parameter int TNEW_W  = SB_TNEW_W,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int SEL_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W  = $clog2(MD_MAX + 1);

    // Entry field widths come from the shared package type.
    if ((REG_AW != SB_REG_AW) || (TNEW_W != SB_TNEW_W)) begin : g_bad_width
        $error("hazard_scoreboard: REG_AW/TNEW_W must match the package entry type");
    end
    if ((2 ** SEL_W) <= STAGES) begin : g_bad_sel
        $error("hazard_scoreboard: SEL_W too narrow for STAGES");
    end

    sb_entry_t [STAGES-1:0] entry_q, entry_d;
    logic                   md_e_q, md_e_d;
    logic                   md_div_q, md_div_d;
    logic [CNT_W-1:0]       md_cnt_q, md_cnt_d;

    logic                   rs_hazard_s, rt_hazard_s;
    logic [SEL_W-1:0]       fwd_rs_s, fwd_rt_s;
    logic                   md_busy_s, stall_s;

    hazard_operand_check #(.STAGES(STAGES), .SEL_W(SEL_W)) u_rs_check (
        .entries (entry_q),
        .op_reg  (bus.d_rs),
        .op_use  (bus.d_rs_use),
        .op_tuse (bus.d_rs_tuse),
        .hazard  (rs_hazard_s),
        .fwd     (fwd_rs_s)
    );

    hazard_operand_check #(.STAGES(STAGES), .SEL_W(SEL_W)) u_rt_check (
        .entries (entry_q),
        .op_reg  (bus.d_rt),
        .op_use  (bus.d_rt_use),
        .op_tuse (bus.d_rt_tuse),
        .hazard  (rt_hazard_s),
        .fwd     (fwd_rt_s)
    );

    assign md_busy_s   = md_e_q | (md_cnt_q != {CNT_W{1'b0}});
    assign stall_s     = bus.d_valid & (rs_hazard_s | rt_hazard_s | (bus.d_md_use & md_busy_s));
    assign bus.stall   = stall_s;
    assign bus.fwd_rs  = fwd_rs_s;
    assign bus.fwd_rt  = fwd_rt_s;
    assign bus.md_busy = md_busy_s;

    // Next state: age the scoreboard, admit D (or a bubble), run the busy window.
    always_comb begin
        entry_d  = entry_q;
        md_e_d   = 1'b0;
        md_div_d = 1'b0;
        md_cnt_d = md_cnt_q;

        if (stall_s) begin
            entry_d[0].wr   = 1'b0;
            entry_d[0].dst  = {SB_REG_AW{1'b0}};
            entry_d[0].tnew = {SB_TNEW_W{1'b0}};
        end else begin
            entry_d[0].wr   = bus.d_valid & bus.d_wr;
            entry_d[0].dst  = bus.d_dst;
            entry_d[0].tnew = bus.d_tnew;
        end
        for (int i = 1; i < STAGES; i++) begin
            entry_d[i].wr   = entry_q[i-1].wr;
            entry_d[i].dst  = entry_q[i-1].dst;
            entry_d[i].tnew = tnew_dec(entry_q[i-1].tnew);
        end

        case (bus.d_md_start)
            MD_MUL: begin
                md_e_d   = bus.d_valid & ~stall_s;
                md_div_d = 1'b0;
            end
            MD_DIV: begin
                md_e_d   = bus.d_valid & ~stall_s;
                md_div_d = 1'b1;
            end
            default: begin
                md_e_d   = 1'b0;
                md_div_d = 1'b0;
            end
        endcase

        if (md_e_q) begin
            md_cnt_d = md_div_q ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end else if (md_cnt_q != {CNT_W{1'b0}}) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q  <= '0;
            md_e_q   <= 1'b0;
            md_div_q <= 1'b0;
            md_cnt_q <= {CNT_W{1'b0}};
        end else begin
            entry_q  <= entry_d;
            md_e_q   <= md_e_d;
            md_div_q <= md_div_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3, MUL_LAT=5, DIV_LAT=10).
module tb_hazard_scoreboard;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cyc;

    hazard_scoreboard_if #(.REG_AW(5), .TNEW_W(3), .SEL_W(2)) bus ();

    hazard_scoreboard #(
        .STAGES(3), .REG_AW(5), .TNEW_W(3), .MUL_LAT(5), .DIV_LAT(10), .SEL_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.d_valid    = 1'b0;
        bus.d_wr       = 1'b0;
        bus.d_dst      = 5'd0;
        bus.d_tnew     = 3'd0;
        bus.d_rs       = 5'd0;
        bus.d_rs_use   = 1'b0;
        bus.d_rs_tuse  = 3'd0;
        bus.d_rt       = 5'd0;
        bus.d_rt_use   = 1'b0;
        bus.d_rt_tuse  = 3'd0;
        bus.d_md_start = 2'd0;
        bus.d_md_use   = 1'b0;
    endtask

    task automatic wr_insn(input logic [4:0] dst, input logic [2:0] tnew);
        bus.d_valid = 1'b1;
        bus.d_wr    = 1'b1;
        bus.d_dst   = dst;
        bus.d_tnew  = tnew;
    endtask

    task automatic rd(input logic [4:0] rs, input logic rs_use, input logic [2:0] rs_tuse,
                      input logic [4:0] rt, input logic rt_use, input logic [2:0] rt_tuse);
        bus.d_valid   = 1'b1;
        bus.d_rs      = rs;
        bus.d_rs_use  = rs_use;
        bus.d_rs_tuse = rs_tuse;
        bus.d_rt      = rt;
        bus.d_rt_use  = rt_use;
        bus.d_rt_tuse = rt_tuse;
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Reset state with a live writer/reader presented in D.
        wr_insn(5'd8, 3'd2);
        rd(5'd8, 1'b1, 3'd0, 5'd8, 1'b1, 3'd0);
        #1;
        chk("rst_stall", bus.stall, 0);
        chk("rst_fwd_rs", bus.fwd_rs, 0);
        chk("rst_fwd_rt", bus.fwd_rt, 0);
        chk("rst_md_busy", bus.md_busy, 0);
        idle();
        reset = 1'b1;
        tick();

        // lw $8 (tnew=2) then add reading $8 with tuse=1.
        wr_insn(5'd8, 3'd2);
        #1 chk("lw_issue_stall", bus.stall, 0);
        tick();
        idle();
        wr_insn(5'd11, 3'd1);
        rd(5'd8, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0);
        #1 chk("lw_use_stall", bus.stall, 1);
        chk("lw_use_fwd_rs", bus.fwd_rs, 0);
        tick();
        // $8 in M with tnew=1: no longer a hazard, not yet forwardable.
        chk("lw_m_stall", bus.stall, 0);
        chk("lw_m_fwd_rs", bus.fwd_rs, 0);
        tick();
        // $8 in W ready; $11 in E with tnew=1, tuse=1 is no hazard.
        idle();
        rd(5'd8, 1'b1, 3'd0, 5'd11, 1'b1, 3'd1);
        #1 chk("lw_w_fwd_rs", bus.fwd_rs, 3);
        chk("lw_w_fwd_rt", bus.fwd_rt, 0);
        chk("lw_w_stall", bus.stall, 0);
        tick();
        flush();

        // add $9 (tnew=1) then beq reading $9 as rt with tuse=0.
        wr_insn(5'd9, 3'd1);
        tick();
        idle();
        rd(5'd0, 1'b0, 3'd0, 5'd9, 1'b1, 3'd0);
        #1 chk("beq_stall", bus.stall, 1);
        chk("beq_fwd_rt_e", bus.fwd_rt, 0);
        tick();
        chk("beq_release", bus.stall, 0);
        chk("beq_fwd_rt_m", bus.fwd_rt, 2);
        tick();
        flush();

        // ori $10, two unrelated writers, then a reader of $10.
        wr_insn(5'd10, 3'd1);
        tick();
        idle();
        wr_insn(5'd12, 3'd1);
        tick();
        idle();
        wr_insn(5'd13, 3'd1);
        tick();
        idle();
        rd(5'd10, 1'b1, 3'd0, 5'd0, 1'b0, 3'd0);
        #1 chk("ori_w_fwd_rs", bus.fwd_rs, 3);
        chk("ori_w_stall", bus.stall, 0);
        tick();
        chk("ori_gone_fwd_rs", bus.fwd_rs, 0);
        flush();

        // Writes to $0 in E/M/W never match.
        wr_insn(5'd0, 3'd2);
        repeat (3) tick();
        idle();
        rd(5'd0, 1'b1, 3'd0, 5'd0, 1'b1, 3'd0);
        #1 chk("r0_stall", bus.stall, 0);
        chk("r0_fwd_rs", bus.fwd_rs, 0);
        chk("r0_fwd_rt", bus.fwd_rt, 0);
        tick();
        flush();

        // Reserved md_start code starts nothing.
        bus.d_valid    = 1'b1;
        bus.d_md_start = 2'd3;
        tick();
        idle();
        #1 chk("md_rsvd_busy", bus.md_busy, 0);

        // mult then mfhi: stall for the whole busy window.
        bus.d_valid    = 1'b1;
        bus.d_md_start = 2'd1;
        bus.d_md_use   = 1'b1;
        #1 chk("mult_issue_stall", bus.stall, 0);
        tick();
        idle();
        wr_insn(5'd14, 3'd1);
        bus.d_md_use = 1'b1;
        #1 chk("mult_busy", bus.md_busy, 1);
        cyc = 0;
        while ((bus.stall === 1'b1) && (cyc < 20)) begin
            cyc++;
            tick();
        end
        chk("mult_stall_cycles", cyc, 5);
        chk("mult_release_busy", bus.md_busy, 0);
        tick();
        flush();

        // div then mfhi: ten-cycle window.
        bus.d_valid    = 1'b1;
        bus.d_md_start = 2'd2;
        bus.d_md_use   = 1'b1;
        #1 chk("div_issue_stall", bus.stall, 0);
        tick();
        idle();
        wr_insn(5'd14, 3'd1);
        bus.d_md_use = 1'b1;
        #1;
        cyc = 0;
        while ((bus.stall === 1'b1) && (cyc < 30)) begin
            cyc++;
            tick();
        end
        chk("div_stall_cycles", cyc, 10);
        chk("div_release_busy", bus.md_busy, 0);
        tick();
        flush();

        // Two writers to $4 (E tnew=1, M tnew=0) with a div in flight; youngest decides.
        bus.d_valid    = 1'b1;
        bus.d_md_start = 2'd2;
        tick();
        idle();
        wr_insn(5'd4, 3'd0);
        tick();
        idle();
        wr_insn(5'd4, 3'd1);
        tick();
        idle();
        rd(5'd4, 1'b1, 3'd0, 5'd0, 1'b0, 3'd0);
        #1 chk("dup_stall", bus.stall, 1);
        chk("dup_fwd_rs", bus.fwd_rs, 0);
        chk("dup_md_busy", bus.md_busy, 1);
        // Asynchronous reset between edges clears everything at once.
        #1 reset = 1'b0;
        #1 chk("midrst_stall", bus.stall, 0);
        chk("midrst_md_busy", bus.md_busy, 0);
        chk("midrst_fwd_rs", bus.fwd_rs, 0);
        #1 reset = 1'b1;
        tick();
        chk("post_rst_stall", bus.stall, 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
